// File: rtl/id_ex_stage.sv
// id_ex_stage: one-entry registered ID/EX pipeline slot.
// Resolves ALU operands (register file data or forwarded EX/MEM and MEM/WB
// results), computes the branch target and hands the instruction to EX with a
// valid/ready handshake. While an instruction is stalled in the slot, its
// register operands keep tracking the forwarding buses.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inValid / inReady             upstream (decode) handshake
//   rs1Idx, rs2Idx, rdIdx         source / destination register indices
//   rs1Data, rs2Data, imm, pc     register file data, immediate, PC
//   aluOp, useImm, regWrite       ALU opcode, opB-from-imm select, writeback enable
//   exFwd*, memFwd*               EX/MEM and MEM/WB forwarding sources
//   flush                         kill held and incoming instruction
//   outValid / outReady           downstream (EX) handshake
//   opA, opB, op, rdOut, regWriteOut, isBranch, branchTarget, storeData
//                                 registered instruction fields toward EX
module id_ex_stage #(
    parameter int unsigned FWD_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [4:0]  rs1Idx,
    input  logic [4:0]  rs2Idx,
    input  logic [4:0]  rdIdx,
    input  logic [31:0] rs1Data,
    input  logic [31:0] rs2Data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic [3:0]  aluOp,
    input  logic        useImm,
    input  logic        regWrite,
    input  logic        exFwdValid,
    input  logic [4:0]  exFwdRd,
    input  logic [31:0] exFwdData,
    input  logic        memFwdValid,
    input  logic [4:0]  memFwdRd,
    input  logic [31:0] memFwdData,
    input  logic        flush,
    input  logic        outReady,
    output logic        outValid,
    output logic [31:0] opA,
    output logic [31:0] opB,
    output logic [3:0]  op,
    output logic [4:0]  rdOut,
    output logic        regWriteOut,
    output logic        isBranch,
    output logic [31:0] branchTarget,
    output logic [31:0] storeData
);

    logic        valid_q, valid_d;
    logic [31:0] opA_q, opA_d;
    logic [31:0] opB_q, opB_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        br_q, br_d;
    logic [31:0] bt_q, bt_d;
    logic [31:0] sd_q, sd_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic        bReg_q, bReg_d;

    logic capture;
    logic hold;
    logic immSel;

    // x0 is hard zero; the younger EX/MEM result wins over MEM/WB.
    function automatic logic [31:0] resolve(
        input logic [4:0]  r,
        input logic [31:0] d,
        input logic        exV,
        input logic [4:0]  exRd,
        input logic [31:0] exD,
        input logic        memV,
        input logic [4:0]  memRd,
        input logic [31:0] memD
    );
        if (r == 5'd0)
            return '0;
        if ((FWD_EN != 0) && exV && (exRd == r))
            return exD;
        if ((FWD_EN != 0) && memV && (memRd == r))
            return memD;
        return d;
    endfunction

    assign inReady = !valid_q || outReady;
    assign capture = inValid && inReady && !flush;
    assign hold    = valid_q && !outReady && !flush;
    // Branches always compare against rs2, never the immediate.
    assign immSel  = useImm && !aluOp[3];

    always_comb begin
        valid_d = valid_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        br_d    = br_q;
        bt_d    = bt_q;
        sd_d    = sd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        bReg_d  = bReg_q;
        if (capture) begin
            valid_d = 1'b1;
            opA_d   = resolve(rs1Idx, rs1Data, exFwdValid, exFwdRd, exFwdData,
                              memFwdValid, memFwdRd, memFwdData);
            sd_d    = resolve(rs2Idx, rs2Data, exFwdValid, exFwdRd, exFwdData,
                              memFwdValid, memFwdRd, memFwdData);
            opB_d   = immSel ? imm : sd_d;
            op_d    = aluOp;
            rd_d    = rdIdx;
            rw_d    = regWrite;
            br_d    = aluOp[3];
            bt_d    = pc + imm;
            rs1_d   = rs1Idx;
            rs2_d   = rs2Idx;
            bReg_d  = !immSel;
        end else if (flush || outReady) begin
            valid_d = 1'b0;
        end else if (hold) begin
            // Stalled: pick up results that were still in flight at capture.
            opA_d = resolve(rs1_q, opA_q, exFwdValid, exFwdRd, exFwdData,
                            memFwdValid, memFwdRd, memFwdData);
            sd_d  = resolve(rs2_q, sd_q, exFwdValid, exFwdRd, exFwdData,
                            memFwdValid, memFwdRd, memFwdData);
            if (bReg_q)
                opB_d = resolve(rs2_q, opB_q, exFwdValid, exFwdRd, exFwdData,
                                memFwdValid, memFwdRd, memFwdData);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            opA_q   <= '0;
            opB_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            br_q    <= 1'b0;
            bt_q    <= '0;
            sd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            bReg_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            br_q    <= br_d;
            bt_q    <= bt_d;
            sd_q    <= sd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            bReg_q  <= bReg_d;
        end
    end

    assign outValid     = valid_q;
    assign opA          = opA_q;
    assign opB          = opB_q;
    assign op           = op_q;
    assign rdOut        = rd_q;
    assign regWriteOut  = rw_q;
    assign isBranch     = br_q;
    assign branchTarget = bt_q;
    assign storeData    = sd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a forwarding build (index 0) and a no-forwarding
// build (index 1) share one stimulus stream and are checked every cycle
// against an instruction-level reference model, plus directed literal cases.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, inValid, useImm, regWrite, exFwdValid, memFwdValid, flush, outReady;
    logic [4:0]  rs1Idx, rs2Idx, rdIdx, exFwdRd, memFwdRd;
    logic [31:0] rs1Data, rs2Data, imm, pc, exFwdData, memFwdData;
    logic [3:0]  aluOp;

    logic        inReady_w[2], outValid_w[2], regWriteOut_w[2], isBranch_w[2];
    logic [31:0] opA_w[2], opB_w[2], branchTarget_w[2], storeData_w[2];
    logic [3:0]  op_w[2];
    logic [4:0]  rdOut_w[2];

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        id_ex_stage #(.FWD_EN((g == 0) ? 1 : 0)) u_dut (
            .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady_w[g]),
            .rs1Idx(rs1Idx), .rs2Idx(rs2Idx), .rdIdx(rdIdx),
            .rs1Data(rs1Data), .rs2Data(rs2Data), .imm(imm), .pc(pc),
            .aluOp(aluOp), .useImm(useImm), .regWrite(regWrite),
            .exFwdValid(exFwdValid), .exFwdRd(exFwdRd), .exFwdData(exFwdData),
            .memFwdValid(memFwdValid), .memFwdRd(memFwdRd), .memFwdData(memFwdData),
            .flush(flush), .outReady(outReady), .outValid(outValid_w[g]),
            .opA(opA_w[g]), .opB(opB_w[g]), .op(op_w[g]), .rdOut(rdOut_w[g]),
            .regWriteOut(regWriteOut_w[g]), .isBranch(isBranch_w[g]),
            .branchTarget(branchTarget_w[g]), .storeData(storeData_w[g])
        );
    end

    // Reference: the instruction currently occupying the slot.
    typedef struct packed {
        logic        v;
        logic [31:0] a, b, sd, bt;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw, br;
        logic [4:0]  s1, s2;
        logic        breg;
    } model_t;

    model_t m[2];

    function automatic logic [31:0] mres(input bit fe, input logic [4:0] r, input logic [31:0] d);
        if (r == 0) return 32'd0;
        if (fe && exFwdValid && exFwdRd == r) return exFwdData;
        if (fe && memFwdValid && memFwdRd == r) return memFwdData;
        return d;
    endfunction

    function automatic model_t mnext(input bit fe, input model_t c);
        model_t n;
        bit acc;
        n = c;
        if (rst) return '0;
        acc = inValid && (!c.v || outReady) && !flush;
        if (acc) begin
            n.v    = 1'b1;
            n.s1   = rs1Idx;
            n.s2   = rs2Idx;
            n.a    = mres(fe, rs1Idx, rs1Data);
            n.sd   = mres(fe, rs2Idx, rs2Data);
            n.breg = !(useImm && !aluOp[3]);
            n.b    = n.breg ? n.sd : imm;
            n.op   = aluOp;
            n.rd   = rdIdx;
            n.rw   = regWrite;
            n.br   = aluOp[3];
            n.bt   = pc + imm;
        end else if (flush || (c.v && outReady)) begin
            n.v = 1'b0;
        end else if (c.v) begin
            n.a  = mres(fe, c.s1, c.a);
            n.sd = mres(fe, c.s2, c.sd);
            if (c.breg) n.b = mres(fe, c.s2, c.b);
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: model and DUTs both sample the inputs now present.
    task automatic tick();
        model_t n0, n1;
        n0 = mnext(1'b1, m[0]);
        n1 = mnext(1'b0, m[1]);
        @(posedge clk);
        m[0] = n0;
        m[1] = n1;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("u%0d.inReady", g), 32'(inReady_w[g]), 32'(!m[g].v || outReady));
                chk($sformatf("u%0d.outValid", g), 32'(outValid_w[g]), 32'(m[g].v));
                chk($sformatf("u%0d.opA", g), opA_w[g], m[g].a);
                chk($sformatf("u%0d.opB", g), opB_w[g], m[g].b);
                chk($sformatf("u%0d.op", g), 32'(op_w[g]), 32'(m[g].op));
                chk($sformatf("u%0d.rdOut", g), 32'(rdOut_w[g]), 32'(m[g].rd));
                chk($sformatf("u%0d.regWriteOut", g), 32'(regWriteOut_w[g]), 32'(m[g].rw));
                chk($sformatf("u%0d.isBranch", g), 32'(isBranch_w[g]), 32'(m[g].br));
                chk($sformatf("u%0d.branchTarget", g), branchTarget_w[g], m[g].bt);
                chk($sformatf("u%0d.storeData", g), storeData_w[g], m[g].sd);
            end
        end
    end

    task automatic idle_inputs();
        inValid = 0; useImm = 0; regWrite = 0; exFwdValid = 0; memFwdValid = 0;
        flush = 0; outReady = 1; rs1Idx = 0; rs2Idx = 0; rdIdx = 0;
        exFwdRd = 0; memFwdRd = 0; rs1Data = 0; rs2Data = 0; imm = 0; pc = 0;
        exFwdData = 0; memFwdData = 0; aluOp = 0;
    endtask

    initial begin
        m[0] = '0;
        m[1] = '0;
        idle_inputs();
        rst = 1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset.outValid", 32'(outValid_w[0]), 32'd0);
        chk("reset.opA", opA_w[0], 32'd0);
        chk("reset.inReady", 32'(inReady_w[0]), 32'd1);
        rst = 0;

        // ADD without forwarding.
        inValid = 1; aluOp = 4'b0000; rs1Idx = 3; rs1Data = 5; rs2Idx = 4; rs2Data = 7;
        rdIdx = 1; regWrite = 1;
        tick();
        chk("add.outValid", 32'(outValid_w[0]), 32'd1);
        chk("add.opA", opA_w[0], 32'd5);
        chk("add.opB", opB_w[0], 32'd7);
        chk("add.op", 32'(op_w[0]), 32'd0);

        // EX/MEM beats MEM/WB; x0 never forwarded; no-forward build ignores both.
        exFwdValid = 1; exFwdRd = 3; exFwdData = 32'h11;
        memFwdValid = 1; memFwdRd = 3; memFwdData = 32'h22;
        tick();
        chk("fwd.opA", opA_w[0], 32'h11);
        chk("nofwd.opA", opA_w[1], 32'd5);
        rs1Idx = 0;
        tick();
        chk("fwd.x0", opA_w[0], 32'd0);
        exFwdValid = 0; memFwdValid = 0;

        // BEQ with useImm: opB stays rs2, target wraps modulo 2^32.
        aluOp = 4'b1000; useImm = 1; imm = 32'h10; pc = 32'h100; rs2Data = 9;
        tick();
        chk("beq.opB", opB_w[0], 32'd9);
        chk("beq.isBranch", 32'(isBranch_w[0]), 32'd1);
        chk("beq.target", branchTarget_w[0], 32'h110);
        pc = 32'hFFFF_FFF8;
        tick();
        chk("beq.wrap", branchTarget_w[0], 32'h8);

        // Stall with late forward into the held rs2.
        aluOp = 4'b0000; useImm = 0; rs1Idx = 2; rs2Idx = 6; rs2Data = 1;
        tick();
        outReady = 0; rs2Data = 32'h55; rs2Idx = 7;
        #1 chk("stall.inReady1", 32'(inReady_w[0]), 32'd0);
        tick();
        chk("stall.opB1", opB_w[0], 32'd1);
        exFwdValid = 1; exFwdRd = 6; exFwdData = 32'hAB;
        tick();
        chk("stall.opB2", opB_w[0], 32'hAB);
        chk("stall.inReady2", 32'(inReady_w[0]), 32'd0);
        chk("stall.nofwd", opB_w[1], 32'd1);
        exFwdValid = 0; inValid = 0; outReady = 1;
        tick();
        chk("stall.release", 32'(outValid_w[0]), 32'd0);

        // Flush while held beats a simultaneous incoming instruction.
        inValid = 1; rs1Idx = 5; rs1Data = 32'h77;
        tick();
        outReady = 0; rs1Data = 32'h99;
        tick();
        flush = 1;
        tick();
        chk("flush.outValid", 32'(outValid_w[0]), 32'd0);
        chk("flush.opA", opA_w[0], 32'h77);
        flush = 0; inValid = 0;

        // Reset mid-hold discards everything.
        inValid = 1; outReady = 1; rs1Data = 32'h1234; pc = 32'h40; imm = 32'h4;
        tick();
        outReady = 0; rst = 1;
        tick();
        chk("rst.outValid", 32'(outValid_w[0]), 32'd0);
        chk("rst.opA", opA_w[0], 32'd0);
        chk("rst.target", branchTarget_w[0], 32'd0);
        rst = 0; inValid = 0; outReady = 1;
        tick();

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) < 2);
            flush       = ($urandom_range(0, 99) < 6);
            inValid     = ($urandom_range(0, 99) < 75);
            outReady    = ($urandom_range(0, 99) < 65);
            rs1Idx      = 5'($urandom_range(0, 7));
            rs2Idx      = 5'($urandom_range(0, 7));
            rdIdx       = 5'($urandom);
            rs1Data     = $urandom;
            rs2Data     = $urandom;
            imm         = $urandom;
            pc          = $urandom;
            aluOp       = 4'($urandom_range(0, 11));
            useImm      = 1'($urandom);
            regWrite    = 1'($urandom);
            exFwdValid  = 1'($urandom);
            exFwdRd     = 5'($urandom_range(0, 7));
            exFwdData   = $urandom;
            memFwdValid = 1'($urandom);
            memFwdRd    = 5'($urandom_range(0, 7));
            memFwdData  = $urandom;
            tick();
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
